// File: rtl/stream_mux_nxw_pkg.sv
// Shared constants and types for the N-input stream multiplexer.
// Arbitration modes, FSM encoding and a modular increment helper.
package stream_mux_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   function automatic int wrap_inc(int v, int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/stream_mux_nxw_if.sv
// Handshake bundle between the producers, the mux and the consumer.
// The mux uses the slave view; the traffic source uses master.
interface stream_mux_nxw_if #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int SW = $clog2(N)
);

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_last;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_last;
   logic [SW-1:0]  out_sel;
   logic           out_ready;
   logic           busy;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last,
      input  out_sel, busy
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last,
      output out_sel, busy
   );

endinterface

// File: rtl/stream_mux_nxw_arb.sv
// Combinational arbiter: rotating search from ptr, or fixed
// priority from channel 0. Grant is one-hot or all zero.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int MODE = MODE_RR,
   parameter int SW   = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  grant
);

   int   base;
   int   idx;
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      base  = (MODE == MODE_FIXED) ? 0 : int'(ptr);
      for (int i = 0; i < N; i++) begin
         idx = base + i;
         if (idx >= N) idx = idx - N;
         if (!found && req[SW'(idx)]) begin
            grant[SW'(idx)] = 1'b1;
            found           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_nxw.sv
// Registered N:1 stream mux with per-packet grant lock and
// round-robin or fixed-priority arbitration.
module stream_mux_nxw
   import stream_mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int MODE = MODE_RR
) (
   input  logic            clk,
   input  logic            rst,
   stream_mux_nxw_if.slave bus
);

   localparam int SW = $clog2(N);

   state_t        state_q, state_d;
   logic [SW-1:0] lock_q, lock_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  req, grant;
   logic [SW-1:0] gidx;
   logic [W-1:0]  sel_data;
   logic          sel_last;
   logic          load_en;
   logic          xfer;

   assign load_en = ~bus.out_valid | bus.out_ready;

   // While locked, only the owning channel may compete.
   always_comb begin
      req = bus.in_valid;
      if (state_q == ST_LOCKED)
         req = bus.in_valid & (N'(1) << lock_q);
   end

   rr_arbiter #(
      .N    (N),
      .MODE (MODE),
      .SW   (SW)
   ) u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .grant (grant)
   );

   assign bus.in_ready = rst ? '0 : (grant & {N{load_en}});
   assign xfer = |(bus.in_valid & bus.in_ready);

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N; i++)
         if (grant[i]) gidx = SW'(i);
   end

   assign sel_data = bus.in_data[gidx*W +: W];
   assign sel_last = bus.in_last[gidx];

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         if (sel_last) begin
            state_d = ST_IDLE;
            ptr_d   = SW'(wrap_inc(int'(gidx), N));
         end else begin
            state_d = ST_LOCKED;
            lock_d  = gidx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lock_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_sel   <= '0;
      end else if (load_en) begin
         bus.out_valid <= xfer;
         if (xfer) begin
            bus.out_data <= sel_data;
            bus.out_last <= sel_last;
            bus.out_sel  <= gidx;
         end
      end
   end

   assign bus.busy = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux_nxw.sv
// Directed bench: round-robin and fixed-priority instances
// driven from one initial block, checked at the falling edge.
module tb_stream_mux_nxw;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   stream_mux_nxw_if #(.N(4), .W(8)) r ();
   stream_mux_nxw_if #(.N(4), .W(8)) f ();

   stream_mux_nxw #(.N(4), .W(8), .MODE(0)) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (r.slave)
   );

   stream_mux_nxw #(.N(4), .W(8), .MODE(1)) dut_fx (
      .clk (clk),
      .rst (rst),
      .bus (f.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      r.in_data   = '0;
      r.in_valid  = '0;
      r.in_last   = '0;
      r.out_ready = 1'b1;
      f.in_data   = '0;
      f.in_valid  = '0;
      f.in_last   = '0;
      f.out_ready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      r.in_valid = 4'hF;
      r.in_last  = 4'hF;
      #7;
      n_cmp++;
      if (r.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid got %b want 0", r.out_valid);
      end
      n_cmp++;
      if (r.out_data !== 8'h00) begin
         n_err++;
         $display("FAIL reset_data got %h want 00", r.out_data);
      end
      n_cmp++;
      if (r.out_sel !== 2'd0) begin
         n_err++;
         $display("FAIL reset_sel got %0d want 0", r.out_sel);
      end
      n_cmp++;
      if (r.out_last !== 1'b0) begin
         n_err++;
         $display("FAIL reset_last got %b want 0", r.out_last);
      end
      n_cmp++;
      if (r.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy got %b want 0", r.busy);
      end
      n_cmp++;
      if (r.in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ready got %b want 0000", r.in_ready);
      end
   endtask

   task automatic test_fixed_order();
      logic [7:0] exp_d;
      do_reset();
      r.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      r.in_last  = 4'hF;
      r.in_valid = 4'hF;
      #1;
      n_cmp++;
      if (r.in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL order_ready0 got %b want 0001", r.in_ready);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         exp_d = 8'hA0 + 8'(k % 4);
         n_cmp++;
         if (r.out_valid !== 1'b1 || r.out_data !== exp_d) begin
            n_err++;
            $display("FAIL order_data[%0d] got %b/%h want 1/%h",
                     k, r.out_valid, r.out_data, exp_d);
         end
         n_cmp++;
         if (r.out_sel !== 2'(k % 4)) begin
            n_err++;
            $display("FAIL order_sel[%0d] got %0d want %0d",
                     k, r.out_sel, k % 4);
         end
      end
      r.in_valid = '0;
      @(negedge clk);
      #1;
      n_cmp++;
      if (r.out_valid !== 1'b0 || r.in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL order_drain got %b/%b want 0/0000",
                  r.out_valid, r.in_ready);
      end
   endtask

   task automatic test_packet_lock();
      do_reset();
      r.in_data  = {8'h00, 8'h20, 8'h10, 8'h00};
      r.in_last  = 4'b0100;
      r.in_valid = 4'b0110;
      #1;
      n_cmp++;
      if (r.in_ready !== 4'b0010 || r.busy !== 1'b0) begin
         n_err++;
         $display("FAIL lock_start got %b/%b want 0010/0",
                  r.in_ready, r.busy);
      end
      @(negedge clk);
      r.in_data[15:8] = 8'h11;
      #1;
      n_cmp++;
      if (r.out_data !== 8'h10 || r.out_sel !== 2'd1) begin
         n_err++;
         $display("FAIL lock_w0 got %h/%0d want 10/1",
                  r.out_data, r.out_sel);
      end
      n_cmp++;
      if (r.busy !== 1'b1 || r.in_ready !== 4'b0010) begin
         n_err++;
         $display("FAIL lock_hold got %b/%b want 1/0010",
                  r.busy, r.in_ready);
      end
      @(negedge clk);
      r.in_data[15:8] = 8'h12;
      r.in_last[1]    = 1'b1;
      #1;
      n_cmp++;
      if (r.out_data !== 8'h11 || r.busy !== 1'b1) begin
         n_err++;
         $display("FAIL lock_w1 got %h/%b want 11/1",
                  r.out_data, r.busy);
      end
      @(negedge clk);
      r.in_valid = 4'b0100;
      #1;
      n_cmp++;
      if (r.out_data !== 8'h12 || r.out_last !== 1'b1) begin
         n_err++;
         $display("FAIL lock_w2 got %h/%b want 12/1",
                  r.out_data, r.out_last);
      end
      n_cmp++;
      if (r.busy !== 1'b0 || r.in_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL lock_release got %b/%b want 0/0100",
                  r.busy, r.in_ready);
      end
      @(negedge clk);
      r.in_valid = '0;
      #1;
      n_cmp++;
      if (r.out_data !== 8'h20 || r.out_sel !== 2'd2) begin
         n_err++;
         $display("FAIL lock_next got %h/%0d want 20/2",
                  r.out_data, r.out_sel);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      r.in_data  = {24'h0, 8'h55};
      r.in_last  = 4'b0001;
      r.in_valid = 4'b0001;
      #1;
      n_cmp++;
      if (r.in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL bp_first got %b want 0001", r.in_ready);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         r.out_ready   = 1'b0;
         r.in_data[7:0] = 8'h66;
         #1;
         n_cmp++;
         if (r.out_valid !== 1'b1 || r.out_data !== 8'h55) begin
            n_err++;
            $display("FAIL bp_hold[%0d] got %b/%h want 1/55",
                     k, r.out_valid, r.out_data);
         end
         n_cmp++;
         if (r.in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_ready[%0d] got %b want 0000",
                     k, r.in_ready);
         end
      end
      @(negedge clk);
      r.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (r.in_ready !== 4'b0001 || r.out_data !== 8'h55) begin
         n_err++;
         $display("FAIL bp_release got %b/%h want 0001/55",
                  r.in_ready, r.out_data);
      end
      @(negedge clk);
      r.in_valid = '0;
      #1;
      n_cmp++;
      if (r.out_valid !== 1'b1 || r.out_data !== 8'h66) begin
         n_err++;
         $display("FAIL bp_next got %b/%h want 1/66",
                  r.out_valid, r.out_data);
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      f.in_data  = {8'h33, 8'h00, 8'h31, 8'h00};
      f.in_last  = 4'b1010;
      f.in_valid = 4'b1010;
      #1;
      n_cmp++;
      if (f.in_ready !== 4'b0010) begin
         n_err++;
         $display("FAIL fp_ready0 got %b want 0010", f.in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (f.out_sel !== 2'd1 || f.out_data !== 8'h31) begin
            n_err++;
            $display("FAIL fp_ch1[%0d] got %0d/%h want 1/31",
                     k, f.out_sel, f.out_data);
         end
         n_cmp++;
         if (f.in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL fp_ready[%0d] got %b want 0010",
                     k, f.in_ready);
         end
      end
      f.in_valid = 4'b1000;
      #1;
      n_cmp++;
      if (f.in_ready !== 4'b1000) begin
         n_err++;
         $display("FAIL fp_drop got %b want 1000", f.in_ready);
      end
      @(negedge clk);
      f.in_valid = '0;
      #1;
      n_cmp++;
      if (f.out_sel !== 2'd3 || f.out_data !== 8'h33) begin
         n_err++;
         $display("FAIL fp_ch3 got %0d/%h want 3/33",
                  f.out_sel, f.out_data);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      r.in_data  = {8'h33, 24'h0};
      r.in_last  = 4'b1000;
      r.in_valid = 4'b1000;
      #1;
      n_cmp++;
      if (r.in_ready !== 4'b1000) begin
         n_err++;
         $display("FAIL wrap_ch3 got %b want 1000", r.in_ready);
      end
      @(negedge clk);
      r.in_data  = {8'h00, 8'h42, 8'h00, 8'h40};
      r.in_last  = 4'b0101;
      r.in_valid = 4'b0101;
      #1;
      n_cmp++;
      if (r.in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL wrap_grant got %b want 0001", r.in_ready);
      end
      n_cmp++;
      if (r.out_sel !== 2'd3 || r.out_data !== 8'h33) begin
         n_err++;
         $display("FAIL wrap_out3 got %0d/%h want 3/33",
                  r.out_sel, r.out_data);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (r.out_sel !== 2'd0 || r.out_data !== 8'h40) begin
         n_err++;
         $display("FAIL wrap_out0 got %0d/%h want 0/40",
                  r.out_sel, r.out_data);
      end
      n_cmp++;
      if (r.in_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL wrap_next got %b want 0100", r.in_ready);
      end
      r.in_valid = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      r.in_data  = {24'h0, 8'h50};
      r.in_last  = 4'b0001;
      r.in_valid = 4'b0001;
      @(negedge clk);
      r.in_data  = {8'h00, 8'h52, 16'h0};
      r.in_last  = 4'b0000;
      r.in_valid = 4'b0100;
      #1;
      n_cmp++;
      if (r.in_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL rm_grant got %b want 0100", r.in_ready);
      end
      @(negedge clk);
      r.in_data[23:16] = 8'h53;
      #1;
      n_cmp++;
      if (r.busy !== 1'b1 || r.out_data !== 8'h52) begin
         n_err++;
         $display("FAIL rm_locked got %b/%h want 1/52",
                  r.busy, r.out_data);
      end
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (r.out_valid !== 1'b0 || r.out_data !== 8'h00) begin
         n_err++;
         $display("FAIL rm_out got %b/%h want 0/00",
                  r.out_valid, r.out_data);
      end
      n_cmp++;
      if (r.busy !== 1'b0 || r.out_sel !== 2'd0 ||
          r.in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL rm_state got %b/%0d/%b want 0/0/0000",
                  r.busy, r.out_sel, r.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      r.in_data  = {8'h00, 8'h62, 8'h00, 8'h60};
      r.in_last  = 4'b0101;
      r.in_valid = 4'b0101;
      #1;
      n_cmp++;
      if (r.in_ready !== 4'b0001 || r.busy !== 1'b0) begin
         n_err++;
         $display("FAIL rm_after got %b/%b want 0001/0",
                  r.in_ready, r.busy);
      end
      @(negedge clk);
      r.in_valid = '0;
      #1;
      n_cmp++;
      if (r.out_sel !== 2'd0 || r.out_data !== 8'h60) begin
         n_err++;
         $display("FAIL rm_word got %0d/%h want 0/60",
                  r.out_sel, r.out_data);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_fixed_order();
      test_packet_lock();
      test_backpressure();
      test_fixed_priority();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
